// File: rtl/mnist_img_loader.sv
// mnist_img_loader
// Frame-assembly front end for the MNIST accelerator. Waits for a header
// byte on the input stream, captures IMG_SIZE pixel bytes into a packed
// image bus, pulses start, then holds off the stream until the accelerator
// reports a fresh rising edge on acc_done.
//
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   s_data       stream byte
//   s_valid      s_data is valid
//   s_ready      loader accepts a byte (transfer on s_valid && s_ready)
//   img_data     packed image, pixel k at [k*8 +: 8]
//   start        one-cycle launch pulse to the accelerator
//   acc_done     accelerator done level
//   busy         high in every state except IDLE
//   frame_err    one-cycle pulse when a frame is aborted by timeout
//   pix_cnt      pixels captured so far in the current frame
module mnist_img_loader #(
  parameter int         IMG_SIZE    = 784,
  parameter logic [7:0] HDR_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [IMG_SIZE*8-1:0] img_data,
  output logic                  start,
  input  logic                  acc_done,
  output logic                  busy,
  output logic                  frame_err,
  output logic [9:0]            pix_cnt
);

  localparam int              GW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [9:0]      LAST_PIX  = 10'(IMG_SIZE - 1);
  localparam logic [9:0]      FULL_CNT  = 10'(IMG_SIZE);
  // The abort fires on the idle cycle that would take the gap counter to
  // TIMEOUT_CYC-1, so compare against the value one below that.
  localparam logic [GW-1:0]   GAP_LIMIT = GW'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIRE = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t        state_r;
  logic          ready_en_r;   // low in reset, high from the first edge after release
  logic          done_prev_r;  // previous acc_done for rise detection
  logic [GW-1:0] gap_r;        // idle cycles since the last accepted byte in LOAD
  logic          xfer_s;
  logic          done_rise_s;

  // s_ready is a pure decode of registered state, gated by the reset-release flop
  assign s_ready     = ready_en_r & ((state_r == IDLE) | (state_r == LOAD));
  assign xfer_s      = s_valid & s_ready;
  assign done_rise_s = acc_done & ~done_prev_r;

  // Frame FSM with registered outputs, image capture and idle-gap timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ready_en_r  <= 1'b0;
      done_prev_r <= 1'b0;
      gap_r       <= '0;
      img_data    <= '0;
      start       <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      pix_cnt     <= 10'd0;
    end else begin
      ready_en_r  <= 1'b1;
      done_prev_r <= acc_done;
      start       <= 1'b0;
      frame_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (xfer_s && (s_data == HDR_BYTE)) begin
            state_r <= LOAD;
            busy    <= 1'b1;
            pix_cnt <= 10'd0;
            gap_r   <= '0;
          end
        end
        LOAD: begin
          if (xfer_s) begin
            // A transfer always wins over a coincident timeout
            img_data[{pix_cnt, 3'b000} +: 8] <= s_data;
            gap_r <= '0;
            if (pix_cnt == LAST_PIX) begin
              pix_cnt <= FULL_CNT;
              state_r <= FIRE;
              start   <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + 10'd1;
            end
          end else if (gap_r == GAP_LIMIT) begin
            // Abort: partial pixels stay in img_data
            frame_err <= 1'b1;
            pix_cnt   <= 10'd0;
            gap_r     <= '0;
            state_r   <= IDLE;
            busy      <= 1'b0;
          end else begin
            gap_r <= gap_r + GW'(1);
          end
        end
        FIRE: begin
          state_r <= WAIT;
        end
        WAIT: begin
          // Only a fresh rise counts; a level held high since before WAIT is ignored
          if (done_rise_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            pix_cnt <= 10'd0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          pix_cnt <= 10'd0;
        end
      endcase
    end
  end

endmodule
